div_controller: RTL and testbench

DIV_CONTROLLER -- requirements
Module: div_controller

---
 rtl/div_controller.sv | 139 +++++++++++++
 tb/tb_div_controller.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/div_controller.sv
// Iterative restoring divider for div/divu. One quotient bit per cycle,
// result committed to HI (remainder) and LO (quotient) when the FIX cycle ends.
module div_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StartDivE,
  input  logic             SignedE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             AbortDiv,
  output logic             DivBusy,
  output logic             DivDone,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder (always < divisor)
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             negq_q, negq_d;   // quotient must be negated
  logic             negr_q, negr_d;   // remainder takes dividend's (negative) sign
  logic             dz_q, dz_d;       // divisor was zero

  // Operand magnitudes; only signed divides take absolute values.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign a_neg = SignedE & SrcAE[WIDTH-1];
  assign b_neg = SignedE & SrcBE[WIDTH-1];
  assign abs_a = a_neg ? -SrcAE : SrcAE;
  assign abs_b = b_neg ? -SrcBE : SrcBE;

  // Restoring step on a WIDTH+1 bit window. Because the shifted remainder is
  // below 2*divisor, the borrow bit of the difference alone tells whether
  // the subtraction stays non-negative.
  logic [WIDTH:0]   rem_sh, diff;
  logic             ge;
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign ge     = ~diff[WIDTH];

  // Sign correction applied in FIX. A zero divisor leaves |dividend| as the
  // remainder, so restoring the dividend's sign reproduces the original SrcAE.
  logic [WIDTH-1:0] q_fix, r_fix;
  assign q_fix = negq_q ? -quo_q : quo_q;
  assign r_fix = negr_q ? -rem_q : rem_q;

  // Next-state, datapath update and DivDone; AbortDiv overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    DivDone = 1'b0;
    case (state_q)
      IDLE: begin
        if (StartDivE) begin
          state_d = ITER;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = abs_a;
          dvs_d   = abs_b;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          dz_d    = (SrcBE == '0);
        end
      end
      ITER: begin
        rem_d = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        DivDone = 1'b1;
        lo_d    = dz_q ? '1 : q_fix;
        hi_d    = r_fix;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (AbortDiv) begin
      state_d = IDLE;
      DivDone = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  assign DivBusy   = (state_q != IDLE);
  assign DivByZero = DivDone & dz_q;
  assign HiOut     = hi_q;
  assign LoOut     = lo_q;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_div_controller.sv
// Directed bench for div_controller: latency, signed/unsigned results,
// divide-by-zero, overflow case, abort, ignored restart and async reset.
module tb_div_controller;

  localparam int W = 32;

  logic         clk, rst;
  logic         StartDivE, SignedE, AbortDiv;
  logic [W-1:0] SrcAE, SrcBE;
  logic         DivBusy, DivDone, DivByZero;
  logic [W-1:0] HiOut, LoOut;

  int n_pass = 0;
  int n_chk  = 0;

  div_controller #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .StartDivE (StartDivE),
    .SignedE   (SignedE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .AbortDiv  (AbortDiv),
    .DivBusy   (DivBusy),
    .DivDone   (DivDone),
    .DivByZero (DivByZero),
    .HiOut     (HiOut),
    .LoOut     (LoOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one divide and check busy, DivDone timing, DivByZero and result.
  task automatic run_div(input string tag, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] elo,
                         input logic [W-1:0] ehi, input logic edz);
    StartDivE = 1'b1; SignedE = s; SrcAE = a; SrcBE = b;
    tick(1);                                  // cycle N+1
    StartDivE = 1'b0;
    chk({tag, ".busy"}, W'(DivBusy), W'(1));
    tick(W - 1);                              // cycle N+W
    chk({tag, ".nodone"}, W'(DivDone), W'(0));
    tick(1);                                  // cycle N+W+1
    chk({tag, ".done"}, W'(DivDone), W'(1));
    chk({tag, ".dz"}, W'(DivByZero), W'(edz));
    tick(1);                                  // cycle N+W+2
    chk({tag, ".lo"}, LoOut, elo);
    chk({tag, ".hi"}, HiOut, ehi);
    chk({tag, ".idle"}, W'(DivBusy), W'(0));
  endtask

  initial begin
    bit seen;
    rst = 1'b1; StartDivE = 1'b0; SignedE = 1'b0; AbortDiv = 1'b0;
    SrcAE = '0; SrcBE = '0;
    #1;
    chk("rst.busy", W'(DivBusy), W'(0));
    chk("rst.done", W'(DivDone), W'(0));
    chk("rst.dz",   W'(DivByZero), W'(0));
    chk("rst.hi",   HiOut, '0);
    chk("rst.lo",   LoOut, '0);
    #12 rst = 1'b0;
    tick(1);

    run_div("divu100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_div("div-7_2",   1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    run_div("div7_-2",   1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
    run_div("div-8_-3",  1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFFE, 1'b0);
    run_div("divu5_0",   1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
    run_div("div-5_0",   1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
    run_div("divovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    run_div("divu_big",  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
    run_div("divu_max1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);

    // Second start at iteration 5 is ignored; first result unaffected.
    StartDivE = 1'b1; SignedE = 1'b0; SrcAE = 32'd100; SrcBE = 32'd7;
    tick(1);                                  // N+1, iteration 0
    StartDivE = 1'b0;
    tick(5);                                  // N+6, iteration 5
    StartDivE = 1'b1; SrcAE = 32'd50; SrcBE = 32'd5;
    tick(1);
    StartDivE = 1'b0;
    tick(26);                                 // N+33
    chk("restart.done", W'(DivDone), W'(1));
    tick(1);
    chk("restart.lo", LoOut, 32'd14);
    chk("restart.hi", HiOut, 32'd2);
    chk("restart.idle", W'(DivBusy), W'(0));

    // Abort at iteration 10: back to idle, no DivDone, HI/LO kept.
    StartDivE = 1'b1; SrcAE = 32'd1000; SrcBE = 32'd3;
    tick(1);
    StartDivE = 1'b0;
    tick(10);                                 // iteration 10
    AbortDiv = 1'b1;
    tick(1);
    AbortDiv = 1'b0;
    chk("abort.busy", W'(DivBusy), W'(0));
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (DivDone) seen = 1'b1;
      tick(1);
    end
    chk("abort.nodone", W'(seen), W'(0));
    chk("abort.lo", LoOut, 32'd14);
    chk("abort.hi", HiOut, 32'd2);

    // Abort during FIX suppresses DivDone and the commit.
    StartDivE = 1'b1; SrcAE = 32'd9; SrcBE = 32'd3;
    tick(1);
    StartDivE = 1'b0;
    tick(W);                                  // FIX cycle
    AbortDiv = 1'b1;
    #1;
    chk("abortfix.done", W'(DivDone), W'(0));
    tick(1);
    AbortDiv = 1'b0;
    chk("abortfix.lo", LoOut, 32'd14);
    chk("abortfix.hi", HiOut, 32'd2);
    chk("abortfix.busy", W'(DivBusy), W'(0));

    // Reset pulse mid-ITER clears everything immediately.
    StartDivE = 1'b1; SrcAE = 32'd1000; SrcBE = 32'd3;
    tick(1);
    StartDivE = 1'b0;
    tick(5);
    #2 rst = 1'b1;
    #1;
    chk("midrst.busy", W'(DivBusy), W'(0));
    chk("midrst.done", W'(DivDone), W'(0));
    chk("midrst.hi", HiOut, '0);
    chk("midrst.lo", LoOut, '0);
    tick(2);
    rst = 1'b0;
    run_div("divu9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
